// File: rtl/common.sv
// Shared scalar types and architectural constants used across the core.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PCINIT = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/pipes.sv
// Pipeline-stage state encodings shared between stage controllers.
package pipes;
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: one ibus request in flight, data_ok -> out_valid next cycle, accept -> next request next cycle.
// The presented instruction is held stable while out_ready is low; a redirect squashes it or drains the in-flight request.
module fetch_pc_ctrl
  import common::*;
  import pipes::*;
#(
  parameter u64 RESET_PC = PCINIT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic [63:0] pred_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           pending_pc_q, pending_pc_d;
  u64           out_pc_q, out_pc_d;
  u32           out_instr_q, out_instr_d;
  logic         out_misalign_q, out_misalign_d;
  logic         pc_misalign;

  assign pc_misalign = (pc_q[1:0] != 2'b00);

  // pc_q stays at the issued address through DRAIN, which keeps ireq_addr stable.
  assign ireq_valid   = ((state_q == REQ) && !pc_misalign) || (state_q == DRAIN);
  assign ireq_addr    = pc_q;
  assign out_valid    = (state_q == HOLD);
  assign out_pc       = out_pc_q;
  assign out_instr    = out_instr_q;
  assign out_misalign = out_misalign_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pending_pc_d   = pending_pc_q;
    out_pc_d       = out_pc_q;
    out_instr_d    = out_instr_q;
    out_misalign_d = out_misalign_q;

    case (state_q)
      REQ: begin
        if (pc_misalign) begin
          // No bus access was made, so a redirect can be taken immediately.
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            state_d        = HOLD;
            out_pc_d       = pc_q;
            out_instr_d    = '0;
            out_misalign_d = 1'b1;
          end
        end else if (iresp_data_ok) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            state_d        = HOLD;
            out_pc_d       = pc_q;
            out_instr_d    = iresp_data;
            out_misalign_d = 1'b0;
          end
        end else if (redirect_valid) begin
          state_d      = DRAIN;
          pending_pc_d = redirect_pc;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          state_d = REQ;
          pc_d    = redirect_pc;
        end else if (out_ready) begin
          state_d = REQ;
          pc_d    = pred_pc;
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pending_pc_d = redirect_pc;
        end
        if (iresp_data_ok) begin
          state_d = REQ;
          pc_d    = pending_pc_d;
        end
      end

      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= REQ;
      pc_q           <= RESET_PC;
      pending_pc_q   <= '0;
      out_pc_q       <= '0;
      out_instr_q    <= '0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pending_pc_q   <= pending_pc_d;
      out_pc_q       <= out_pc_d;
      out_instr_q    <= out_instr_d;
      out_misalign_q <= out_misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pred_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  int n_total = 0;
  int n_bad   = 0;

  fetch_pc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pred_pc        (pred_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    pred_pc        = 64'h0;
    out_ready      = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_instr", out_instr, 0);
    check_eq("rst_out_misalign", out_misalign, 0);

    reset = 1'b0;
    tick();
    check_eq("first_ireq_valid", ireq_valid, 1);
    check_eq("first_ireq_addr", ireq_addr, 64'h8000_0000);

    // data_ok two cycles into the request
    tick();
    check_eq("req_wait_addr", ireq_addr, 64'h8000_0000);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0013;
    tick();
    iresp_data_ok = 1'b0;
    iresp_data    = 32'hdead_beef;
    check_eq("hold_out_valid", out_valid, 1);
    check_eq("hold_out_pc", out_pc, 64'h8000_0000);
    check_eq("hold_out_instr", out_instr, 32'h0000_0013);
    check_eq("hold_ireq_valid", ireq_valid, 0);

    // Stall in HOLD, with a stray data_ok that must be ignored
    for (int i = 0; i < 5; i++) begin
      iresp_data_ok = (i == 2);
      tick();
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_out_pc", out_pc, 64'h8000_0000);
      check_eq("stall_out_instr", out_instr, 32'h0000_0013);
    end
    iresp_data_ok = 1'b0;

    out_ready = 1'b1;
    pred_pc   = 64'h8000_0004;
    tick();
    out_ready = 1'b0;
    check_eq("accept_out_valid", out_valid, 0);
    check_eq("accept_ireq_valid", ireq_valid, 1);
    check_eq("accept_ireq_addr", ireq_addr, 64'h8000_0004);

    // Complete 8000_0004, predictor loops back to 8000_0000
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h00a0_0093;
    tick();
    iresp_data_ok = 1'b0;
    check_eq("i2_out_pc", out_pc, 64'h8000_0004);
    check_eq("i2_out_instr", out_instr, 32'h00a0_0093);
    out_ready = 1'b1;
    pred_pc   = 64'h8000_0000;
    tick();
    out_ready = 1'b0;
    check_eq("loop_ireq_addr", ireq_addr, 64'h8000_0000);

    // Redirect one cycle after the request issues; response 3 cycles later is discarded
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_ireq_valid", ireq_valid, 1);
      check_eq("drain_ireq_addr", ireq_addr, 64'h8000_0000);
      check_eq("drain_out_valid", out_valid, 0);
      if (i < 2) tick();
    end
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0bad;
    tick();
    iresp_data_ok = 1'b0;
    check_eq("post_drain_out_valid", out_valid, 0);
    check_eq("post_drain_ireq_valid", ireq_valid, 1);
    check_eq("post_drain_addr", ireq_addr, 64'h8000_0100);

    // Enter DRAIN, then two redirects inside it: youngest wins
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0080;
    tick();
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_pc    = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    check_eq("dbl_drain_addr", ireq_addr, 64'h8000_0100);
    iresp_data_ok = 1'b1;
    tick();
    iresp_data_ok = 1'b0;
    check_eq("dbl_out_valid", out_valid, 0);
    check_eq("dbl_next_addr", ireq_addr, 64'h8000_0200);

    // Redirect and out_ready together in HOLD: redirect wins
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0033;
    tick();
    iresp_data_ok = 1'b0;
    check_eq("r5_out_pc", out_pc, 64'h8000_0200);
    check_eq("r5_out_instr", out_instr, 32'h0000_0033);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    out_ready      = 1'b1;
    pred_pc        = 64'h8000_0204;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check_eq("r5_out_valid", out_valid, 0);
    check_eq("r5_next_addr", ireq_addr, 64'h8000_0400);

    // Misaligned redirect target: no bus access, presented with out_misalign
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0000_0013;
    tick();
    iresp_data_ok = 1'b0;
    check_eq("r6_out_pc", out_pc, 64'h8000_0400);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    check_eq("mis_req_ireq_valid", ireq_valid, 0);
    check_eq("mis_req_out_valid", out_valid, 0);
    tick();
    check_eq("mis_ireq_valid", ireq_valid, 0);
    check_eq("mis_out_valid", out_valid, 1);
    check_eq("mis_flag", out_misalign, 1);
    check_eq("mis_out_instr", out_instr, 0);
    check_eq("mis_out_pc", out_pc, 64'h8000_0102);

    out_ready = 1'b1;
    pred_pc   = 64'h8000_0104;
    tick();
    out_ready = 1'b0;
    check_eq("mis_next_addr", ireq_addr, 64'h8000_0104);
    check_eq("mis_next_ireq_valid", ireq_valid, 1);

    // Reset in the middle of a request
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_addr", ireq_addr, 64'h8000_0000);
    check_eq("mid_rst_out_pc", out_pc, 0);
    check_eq("mid_rst_misalign", out_misalign, 0);
    tick();
    check_eq("mid_rst_ireq_valid", ireq_valid, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
